// File: rtl/mips_mem_pkg.sv
// Shared encodings and helpers for the mips_memory2 memory model.
package mips_mem_pkg;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8002_0000;

    typedef enum logic [1:0] {
        SZ_1W  = 2'b00,
        SZ_4W  = 2'b01,
        SZ_8W  = 2'b10,
        SZ_16W = 2'b11
    } access_size_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } mem_state_t;

    function automatic logic [4:0] beat_count(input logic [1:0] size);
        case (size)
            SZ_4W:   beat_count = 5'd4;
            SZ_8W:   beat_count = 5'd8;
            SZ_16W:  beat_count = 5'd16;
            default: beat_count = 5'd1;
        endcase
    endfunction

endpackage

// File: rtl/mips_mem_array.sv
// Byte-wide storage accessed as big-endian 32-bit words; out-of-range words
// ignore writes and read back as zero.
module mips_mem_array
    import mips_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int          MEM_BYTES = 1048576
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic        re,
    input  logic [29:0] word_addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);

    localparam int          AW    = $clog2(MEM_BYTES);
    localparam logic [29:0] WORDS = 30'(MEM_BYTES / 4);

    logic [7:0]    mem [MEM_BYTES];
    logic [29:0]   word_off;
    logic          in_range;
    logic [AW-3:0] idx;

    // Unsigned wrap makes addresses below the base land far above WORDS.
    assign word_off = word_addr - BASE_ADDR[31:2];
    assign in_range = (word_off < WORDS);
    assign idx      = word_off[AW-3:0];

    always_ff @(posedge clk) begin
        if (we && in_range) begin
            mem[{idx, 2'd0}] <= wdata[31:24];
            mem[{idx, 2'd1}] <= wdata[23:16];
            mem[{idx, 2'd2}] <= wdata[15:8];
            mem[{idx, 2'd3}] <= wdata[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= 32'h0;
        end else if (re) begin
            rdata <= in_range ? {mem[{idx, 2'd0}], mem[{idx, 2'd1}],
                                 mem[{idx, 2'd2}], mem[{idx, 2'd3}]} : 32'h0;
        end
    end

endmodule

// File: rtl/mips_memory2.sv
// Enable/busy memory front end: accepts single or burst accesses in IDLE and
// walks consecutive words, one beat per clock, until the burst completes.
module mips_memory2
    import mips_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int          MEM_BYTES = 1048576
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    input  logic [1:0]  access_size,
    input  logic        rw,
    input  logic        enable,
    output logic        busy
);

    mem_state_t  state, next_state;
    logic [3:0]  beat, next_beat;
    logic [3:0]  last_q;
    logic [29:0] base_q;
    logic        rw_q;

    logic        beat_active;
    logic        beat_rw;
    logic [29:0] beat_addr;
    logic        accept;

    // Byte-lane bits of the request address play no part in word accesses.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr[1:0];

    assign accept = (state == ST_IDLE) && enable;
    assign busy   = (state == ST_BURST);

    always_comb begin
        next_state  = state;
        next_beat   = beat;
        beat_active = 1'b0;
        beat_rw     = rw;
        beat_addr   = addr[31:2];
        case (state)
            ST_IDLE: begin
                if (enable) begin
                    beat_active = 1'b1;
                    if (beat_count(access_size) > 5'd1) begin
                        next_state = ST_BURST;
                        next_beat  = 4'd1;
                    end
                end
            end
            ST_BURST: begin
                beat_active = 1'b1;
                beat_rw     = rw_q;
                beat_addr   = base_q + 30'(beat);
                if (beat == last_q) begin
                    next_state = ST_IDLE;
                    next_beat  = 4'd0;
                end else begin
                    next_beat = beat + 4'd1;
                end
            end
            default: begin
                next_state = ST_IDLE;
                next_beat  = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            beat   <= 4'd0;
            last_q <= 4'd0;
            base_q <= 30'd0;
            rw_q   <= 1'b0;
        end else begin
            state <= next_state;
            beat  <= next_beat;
            if (accept) begin
                base_q <= addr[31:2];
                rw_q   <= rw;
                last_q <= 4'(beat_count(access_size) - 5'd1);
            end
        end
    end

    mips_mem_array #(
        .BASE_ADDR(BASE_ADDR),
        .MEM_BYTES(MEM_BYTES)
    ) u_array (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (beat_active && beat_rw),
        .re       (beat_active && !beat_rw),
        .word_addr(beat_addr),
        .wdata    (din),
        .rdata    (dout)
    );

endmodule

// File: tb/tb_mips_memory2.sv
// Directed vector bench for mips_memory2: per-cycle vector table plus a
// hand-written reset-mid-burst sequence.
module tb_mips_memory2;
  import mips_mem_pkg::*;

  localparam logic [31:0] BASE = 32'h8002_0000;
  localparam int          MEMB = 1048576;
  localparam logic [31:0] TOP  = BASE + 32'(MEMB);

  typedef struct {
    logic        en;
    logic        rw;
    logic [1:0]  sz;
    logic [31:0] a;
    logic [31:0] d;
    logic        exp_busy;
    logic [31:0] exp_dout;
  } vec_t;

  vec_t vecs[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] din = 32'h0;
  logic [31:0] dout;
  logic [1:0]  access_size = 2'b00;
  logic        rw = 1'b0;
  logic        enable = 1'b0;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // clock/reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  mips_memory2 #(
    .BASE_ADDR(BASE),
    .MEM_BYTES(MEMB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .addr       (addr),
    .din        (din),
    .dout       (dout),
    .access_size(access_size),
    .rw         (rw),
    .enable     (enable),
    .busy       (busy)
  );

  function automatic void add(input logic en, input logic rwv, input logic [1:0] sz,
                              input logic [31:0] a, input logic [31:0] d,
                              input logic eb, input logic [31:0] ed);
    vec_t v;
    v.en = en; v.rw = rwv; v.sz = sz; v.a = a; v.d = d;
    v.exp_busy = eb; v.exp_dout = ed;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic rwv, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] d);
    enable = en; rw = rwv; access_size = sz; addr = a; din = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] oor_rd[4];
    oor_rd[0] = 32'hA000_0000; oor_rd[1] = 32'hA000_0001;
    oor_rd[2] = 32'h0;         oor_rd[3] = 32'h0;

    // idle with enable low
    add(0, 0, SZ_1W, 32'h0, 32'h0, 0, 32'h0);
    add(0, 0, SZ_1W, 32'h0, 32'h0, 0, 32'h0);
    // single write then single read
    add(1, 1, SZ_1W, BASE + 32'h10, 32'hDEAD_BEEF, 0, 32'h0);
    add(0, 0, SZ_1W, 32'h0, 32'h0, 0, 32'h0);
    add(1, 0, SZ_1W, BASE + 32'h10, 32'h0, 0, 32'hDEAD_BEEF);
    add(0, 0, SZ_1W, 32'h0, 32'h0, 0, 32'hDEAD_BEEF);
    // two back-to-back 8-word write bursts; addr switches as busy falls
    for (int k = 0; k < 16; k++)
      add(1, 1, SZ_8W, (k < 8) ? BASE : BASE + 32'h20, 32'h1000_0000 + 32'(k),
          (k % 8) != 7, 32'hDEAD_BEEF);
    add(0, 0, SZ_1W, 32'h0, 32'h0, 0, 32'hDEAD_BEEF);
    // 8-word read; mid-burst addr/rw/size/din changes must be ignored
    for (int k = 0; k < 8; k++) begin
      if (k == 0) add(1, 0, SZ_8W, BASE, 32'h0, 1, 32'h1000_0000);
      else add(1, 1, SZ_1W, BASE + 32'h100, 32'hFFFF_FFFF, k != 7, 32'h1000_0000 + 32'(k));
    end
    add(0, 0, SZ_1W, 32'h0, 32'h0, 0, 32'h1000_0007);
    // second block read back
    for (int k = 0; k < 8; k++) begin
      if (k == 0) add(1, 0, SZ_8W, BASE + 32'h20, 32'h0, 1, 32'h1000_0008);
      else add(0, 0, SZ_1W, 32'h0, 32'h0, k != 7, 32'h1000_0008 + 32'(k));
    end
    // below base reads zero; low address bits are ignored
    add(1, 0, SZ_1W, 32'h8001_FFFC, 32'h0, 0, 32'h0);
    add(1, 0, SZ_1W, BASE + 32'h13, 32'h0, 0, 32'h1000_0004);
    add(1, 0, SZ_1W, 32'h8001_FFFC, 32'h0, 0, 32'h0);
    // 4-word write straddling the top of the range
    for (int k = 0; k < 4; k++)
      add(1, 1, SZ_4W, TOP - 32'd8, 32'hA000_0000 + 32'(k), k != 3, 32'h0);
    add(0, 0, SZ_1W, 32'h0, 32'h0, 0, 32'h0);
    add(1, 0, SZ_1W, TOP - 32'd8, 32'h0, 0, 32'hA000_0000);
    add(1, 0, SZ_1W, TOP - 32'd4, 32'h0, 0, 32'hA000_0001);
    add(1, 0, SZ_1W, BASE + 32'h10, 32'h0, 0, 32'h1000_0004);
    add(1, 0, SZ_1W, TOP, 32'h0, 0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      if (k == 0) add(1, 0, SZ_4W, TOP - 32'd8, 32'h0, 1, oor_rd[0]);
      else add(0, 0, SZ_1W, 32'h0, 32'h0, k != 3, oor_rd[k]);
    end
    add(0, 0, SZ_1W, 32'h0, 32'h0, 0, 32'h0);

    // reset state
    step();
    step();
    check("reset_busy", 0, 32'(busy), 32'h0);
    check("reset_dout", 0, dout, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].en, vecs[i].rw, vecs[i].sz, vecs[i].a, vecs[i].d);
      step();
      check("busy", i, 32'(busy), 32'(vecs[i].exp_busy));
      check("dout", i, dout, vecs[i].exp_dout);
    end

    // reset asserted mid 16-word read burst
    drive(1, 0, SZ_16W, BASE, 32'h0);
    step();
    drive(0, 0, SZ_1W, 32'h0, 32'h0);
    check("rst_seq_busy0", 0, 32'(busy), 32'h1);
    check("rst_seq_dout0", 0, dout, 32'h1000_0000);
    step();
    check("rst_seq_busy1", 1, 32'(busy), 32'h1);
    check("rst_seq_dout1", 1, dout, 32'h1000_0001);
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", 2, 32'(busy), 32'h0);
    check("async_rst_dout", 2, dout, 32'h0);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_busy", 3 + i, 32'(busy), 32'h0);
      check("post_rst_dout", 3 + i, dout, 32'h0);
    end
    // storage survives reset
    drive(1, 0, SZ_1W, BASE + 32'h4, 32'h0);
    step();
    drive(0, 0, SZ_1W, 32'h0, 32'h0);
    check("post_rst_keep", 6, dout, 32'h1000_0001);
    check("post_rst_single_busy", 6, 32'(busy), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_memory2.md
Name: mips_memory2

Overview:
- Byte-addressed, big-endian, word-wide instruction/data memory model for the MIPS pipeline testbench and core.
- Mapped at a fixed base address (0x8002_0000).
- Supports single-word and 4/8/16-word burst reads and writes.
- Uses an enable/busy handshake.

Parameters:
- BASE_ADDR, 32'h8002_0000, byte address of memory byte 0.
- MEM_BYTES, 1048576, storage size in bytes (multiple of 4).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- addr  input  32  byte address of first word of an access; bits [1:0] ignored
- din  input  32  write data, big-endian (din[31:24] is the lowest byte address)
- dout  output  32  read data, big-endian
- access_size  input  2  burst length: 00=1, 01=4, 10=8, 11=16 words
- rw  input  1  1=write, 0=read
- enable  input  1  request; sampled only when idle
- busy  output  1  high while a multi-word burst is in progress

Behaviour:
- Reset (rst_n=0, asynchronous):
  - busy=0, dout=0, beat counter=0, state IDLE.
  - Storage contents are not cleared.
  - Reset mid-burst aborts the burst.
- States:
  - IDLE: busy=0.
  - BURST: busy=1.
- Accept rule: at a rising edge in IDLE with enable=1, the access is accepted.
  - addr, rw and access_size are latched.
  - This edge is beat 0 and addresses word addr&~3.
- Beat k (k=0..N-1) addresses byte (addr&~3)+4k. Offset = that address − BASE_ADDR.
- Write beat: din is written at that edge as 4 bytes, MSB to the lowest offset.
- Read beat: the word at the beat's offset is registered into dout at that edge.
  - It is valid for the following cycle: 1-cycle latency per beat, one word per cycle.
  - dout holds its last value otherwise.
- N=1: stays IDLE; busy never rises.
- N>1: after beat 0, go to BURST.
  - Beats 1..N-1 occur on the next N-1 consecutive edges.
  - enable, addr, rw and access_size are ignored during BURST.
  - Burst cannot stall or be cancelled except by reset.
- After beat N-1, return to IDLE; busy falls in that same cycle.
  - If enable=1 at the next edge, a new access is accepted back-to-back, with no gap cycle.
- Out-of-range beat (offset < 0 or offset ≥ MEM_BYTES):
  - write is ignored; read returns 32'h0.
  - The burst still consumes the beat.
- Address arithmetic is 32-bit and unsigned. A burst crossing the end of the range does not wrap; its beats go out-of-range.
- Enable low in IDLE: no operation; dout unchanged.

Decomposition:
- Package mips_mem_pkg holds:
  - access-size encodings: SZ_1W=2'b00, SZ_4W=2'b01, SZ_8W=2'b10, SZ_16W=2'b11
  - a function mapping the encoding to beat count
  - default BASE_ADDR
- One sub-module, mips_mem_array:
  - synchronous byte array
  - 32-bit big-endian word write with write enable
  - registered word read
  - in-range check
- mips_memory2 holds the handshake FSM, beat counter and address generator.

Test Plan:
- Reset: assert rst_n=0 mid-burst → busy=0, dout=0 immediately; after release, idle with enable=0 → busy stays 0.
- Single write/read:
  - Write 32'hDEADBEEF to 0x8002_0010 (access_size 00, rw=1) → busy never rises.
  - Read same address → dout=32'hDEADBEEF one cycle after the accept edge.
- 8-word burst write:
  - enable=1, rw=1, access_size=10, addr=0x8002_0000, din=32'h1000_0000+k on beat k → busy high for 7 cycles after accept.
  - Words 0x8002_0000..0x8002_001C then hold those values.
- Back-to-back 8-word write bursts:
  - enable held 1; addr changes to 0x8002_0020 on the cycle busy falls.
  - The second burst is accepted with no idle gap.
  - 16 contiguous words are stored.
- 8-word burst read of the above:
  - dout sequence is 32'h1000_0000..32'h1000_0007 on consecutive cycles.
  - Changing addr and rw mid-burst has no effect.
- Out-of-range:
  - Read 0x8001_FFFC → dout=0.
  - 4-word write starting at BASE_ADDR+MEM_BYTES−8 → the first two words are stored and the last two are dropped; busy lasts 3 cycles.
